psf_axi_rd_arb: RTL and testbench
=================================

Name: psf_axi_rd_arb

Overview:
- Parametrised N-master AXI4 read-channel arbiter with segment stripping. It merges the CPU-side read masters (icache, dmem, and later DMA or debug) onto one downstream AXI read port.
- It replaces per-master address tie-offs with a single arbitrated, registered AR path and a routed R path.
- It adds round-robin arbitration and burst-length checking, which the current point-to-point wiring lacks.
- It sits between the CPU top-level masters and the memory interconnect.

Parameters:
- NUM_PORTS, 2, number of upstream read masters (1..8).
- ARB_RR, 1, arbitration mode: 1 = round-robin; 0 = fixed priority, lowest index wins.
- SEG_STRIP, 1, when 1, the downstream ARADDR[31:29] is forced to 3'b0 (KSEG0/KSEG1 alias removal).
- ID_W, 4, AXI ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous assert, active-low.
- in_arvalid_i  in  NUM_PORTS  per-master ARVALID.
- in_araddr_i  in  NUM_PORTS*32  per-master ARADDR; port p occupies bits [p*32+:32].
- in_arid_i  in  NUM_PORTS*ID_W  per-master ARID.
- in_arlen_i  in  NUM_PORTS*8  per-master ARLEN.
- in_arburst_i  in  NUM_PORTS*2  per-master ARBURST.
- in_arsize_i  in  NUM_PORTS*3  per-master ARSIZE.
- in_arready_o  out  NUM_PORTS  per-master ARREADY.
- in_rvalid_o  out  NUM_PORTS  per-master RVALID.
- in_rdata_o  out  32  shared RDATA.
- in_rresp_o  out  2  shared RRESP.
- in_rid_o  out  ID_W  shared RID.
- in_rlast_o  out  1  shared RLAST.
- in_rready_i  in  NUM_PORTS  per-master RREADY.
- out_arvalid_o  out  1  downstream ARVALID.
- out_araddr_o  out  32  downstream ARADDR.
- out_arid_o  out  ID_W  downstream ARID.
- out_arlen_o  out  8  downstream ARLEN.
- out_arburst_o  out  2  downstream ARBURST.
- out_arsize_o  out  3  downstream ARSIZE.
- out_arready_i  in  1  downstream ARREADY.
- out_rvalid_i  in  1  downstream RVALID.
- out_rdata_i  in  32  downstream RDATA.
- out_rresp_i  in  2  downstream RRESP.
- out_rid_i  in  ID_W  downstream RID.
- out_rlast_i  in  1  downstream RLAST.
- out_rready_o  out  1  downstream RREADY.
- grant_o  out  NUM_PORTS  one-hot owner of the current transaction; zero when IDLE.
- err_o  out  1  sticky burst-length protocol error.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state: FSM = IDLE; all AR output registers = 0; out_arvalid_o = 0; grant_o = 0; err_o = 0; RR pointer = NUM_PORTS-1, so port 0 wins first.
- State IDLE:
  - The winner is computed combinationally from in_arvalid_i.
  - In the same cycle, in_arready_o[winner] = 1; all other in_arready_o bits = 0.
  - On that handshake, the winner's AR fields are captured into registers, grant is registered, and the FSM goes to ADDR.
  - With no request, the FSM stays in IDLE and all in_arready_o bits = 0.
- State ADDR:
  - out_arvalid_o = 1 and the AR outputs come from registers; they are held stable until out_arready_i = 1.
  - On handshake, beat_cnt is cleared to 0 and the FSM goes to DATA.
  - All in_arready_o bits = 0.
- State DATA (R path is combinational):
  - in_rvalid_o[g] = out_rvalid_i; the other in_rvalid_o bits = 0.
  - out_rready_o = in_rready_i[g].
  - in_rdata_o, in_rresp_o, in_rid_o and in_rlast_o are direct copies of the downstream R signals.
- R-beat handshake (out_rvalid_i & out_rready_o):
  - beat_cnt increments, 8-bit.
  - rlast with beat_cnt == len_q: FSM goes to IDLE; the RR pointer is updated to g.
  - rlast with beat_cnt != len_q: err_o is set; FSM still goes to IDLE.
  - No rlast with beat_cnt == len_q: err_o is set; FSM stays in DATA until rlast arrives.
- Outside DATA: out_rready_o = 0 and all in_rvalid_o bits = 0. Stray downstream R beats are back-pressured and never routed.
- Arbitration:
  - RR: search from pointer+1 upward, modulo NUM_PORTS.
  - Fixed (ARB_RR = 0): lowest index with arvalid wins; the pointer is unused.
  - Simultaneous requests are resolved only in IDLE. Requests arriving in ADDR or DATA wait with arready = 0.
- Address output: out_araddr_o = SEG_STRIP ? {3'b0, addr_q[28:0]} : addr_q. All other AR fields pass unmodified.
- Concurrency: one transaction outstanding at a time. There is no ID remapping; RID is returned unchanged.
- Latency:
  - Upstream handshake in cycle N gives out_arvalid_o = 1 in cycle N+1.
  - Final rlast handshake in cycle M means a new upstream handshake is possible in cycle M+1.
- Reset mid-burst: the FSM returns to IDLE immediately. Upstream masters must also be reset; no drain is performed.
- err_o clears only on reset.

Test Plan:
- Single master: port0 AR addr 0xBFC00100, len 3 accepted at cycle 1. Expect out_arvalid_o = 1 at cycle 2 with out_araddr_o = 0x1FC00100. Four beats (rdata 0x11..0x44) delivered to port0 only; grant_o = 2'b01; FSM back in IDLE after the beat-3 rlast.
- RR fairness, ARB_RR = 1, NUM_PORTS = 2: both ports hold arvalid continuously with len 0. Grant order is 0,1,0,1 over four transactions; in_arready_o is never asserted for the waiting port.
- Fixed priority, ARB_RR = 0: both ports request continuously. Port0 wins every transaction and port1 starves.
- Back-pressure: out_arready_i held 0 for 5 cycles, then in_rready_i[1] = 0 for 3 cycles mid-burst. AR fields stay stable; out_rready_o = 0 during the stall; no beats are lost or duplicated.
- Protocol errors, in two runs: (a) len 3 with rlast on beat 1 gives err_o = 1 and the FSM returns to IDLE; (b) len 0 with rlast not set on beat 0 gives err_o = 1 and the FSM waits in DATA until rlast.
- Async reset: assert rst_ni low during DATA, between clock edges. Outputs clear immediately (out_arvalid_o = 0, grant_o = 0, err_o = 0, out_rready_o = 0). After release, port 0 wins the first request.

Source files
------------

// File: rtl/psf_axi_rd_arb.sv
// psf_axi_rd_arb: N-master AXI4 read-channel arbiter.
// One registered AR path towards the memory interconnect, combinational R
// routing back to the owning master, round-robin or fixed-priority grant,
// optional KSEG0/KSEG1 alias removal and a sticky burst-length error flag.
// A single transaction is outstanding at any time.
module psf_axi_rd_arb #(
  parameter int NUM_PORTS = 2,
  parameter int ARB_RR    = 1,
  parameter int SEG_STRIP = 1,
  parameter int ID_W      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_PORTS-1:0]      in_arvalid_i,
  input  logic [NUM_PORTS*32-1:0]   in_araddr_i,
  input  logic [NUM_PORTS*ID_W-1:0] in_arid_i,
  input  logic [NUM_PORTS*8-1:0]    in_arlen_i,
  input  logic [NUM_PORTS*2-1:0]    in_arburst_i,
  input  logic [NUM_PORTS*3-1:0]    in_arsize_i,
  output logic [NUM_PORTS-1:0]      in_arready_o,
  output logic [NUM_PORTS-1:0]      in_rvalid_o,
  output logic [31:0]               in_rdata_o,
  output logic [1:0]                in_rresp_o,
  output logic [ID_W-1:0]           in_rid_o,
  output logic                      in_rlast_o,
  input  logic [NUM_PORTS-1:0]      in_rready_i,
  output logic                      out_arvalid_o,
  output logic [31:0]               out_araddr_o,
  output logic [ID_W-1:0]           out_arid_o,
  output logic [7:0]                out_arlen_o,
  output logic [1:0]                out_arburst_o,
  output logic [2:0]                out_arsize_o,
  input  logic                      out_arready_i,
  input  logic                      out_rvalid_i,
  input  logic [31:0]               out_rdata_i,
  input  logic [1:0]                out_rresp_i,
  input  logic [ID_W-1:0]           out_rid_i,
  input  logic                      out_rlast_i,
  output logic                      out_rready_o,
  output logic [NUM_PORTS-1:0]      grant_o,
  output logic                      err_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [7:0]           len_q, len_d;
  logic [1:0]           burst_q, burst_d;
  logic [2:0]           size_q, size_d;
  logic                 arvalid_q, arvalid_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic                 err_q, err_d;
  logic [PW-1:0]        ptr_q, ptr_d;

  logic                 win_valid_s;
  logic [PW-1:0]        win_idx_s;
  logic [PW-1:0]        cand_s;
  logic [NUM_PORTS-1:0] win_onehot_s;
  logic [31:0]          sel_addr_s;
  logic [ID_W-1:0]      sel_id_s;
  logic [7:0]           sel_len_s;
  logic [1:0]           sel_burst_s;
  logic [2:0]           sel_size_s;
  logic                 r_hs_s;

  // Port index 'off' positions above 'base', wrapping at NUM_PORTS.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    return PW'(sum_v % NUM_PORTS);
  endfunction

  // Winner search: round-robin starts just above the pointer, fixed starts at port 0.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_RR != 0) begin
        cand_s = next_idx(ptr_q, i + 1);
      end else begin
        cand_s = PW'(i);
      end
      if (!win_valid_s && in_arvalid_i[cand_s]) begin
        win_valid_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Select the winning master's AR fields and build its one-hot grant.
  always_comb begin
    sel_addr_s   = 32'h0000_0000;
    sel_id_s     = '0;
    sel_len_s    = 8'h00;
    sel_burst_s  = 2'b00;
    sel_size_s   = 3'b000;
    win_onehot_s = '0;
    win_onehot_s[win_idx_s] = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (win_idx_s == PW'(p)) begin
        sel_addr_s  = in_araddr_i[p*32 +: 32];
        sel_id_s    = in_arid_i[p*ID_W +: ID_W];
        sel_len_s   = in_arlen_i[p*8 +: 8];
        sel_burst_s = in_arburst_i[p*2 +: 2];
        sel_size_s  = in_arsize_i[p*3 +: 3];
      end else begin
        sel_addr_s  = sel_addr_s;
      end
    end
  end

  assign r_hs_s = out_rvalid_i & out_rready_o;

  // Next-state logic for the IDLE -> ADDR -> DATA transaction sequence.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    burst_d    = burst_q;
    size_d     = size_q;
    arvalid_d  = arvalid_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          addr_d    = sel_addr_s;
          id_d      = sel_id_s;
          len_d     = sel_len_s;
          burst_d   = sel_burst_s;
          size_d    = sel_size_s;
          arvalid_d = 1'b1;
          grant_d   = win_onehot_s;
          gidx_d    = win_idx_s;
          state_d   = ST_ADDR;
        end else begin
          grant_d   = '0;
        end
      end
      ST_ADDR: begin
        if (out_arready_i) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = 8'h00;
          state_d    = ST_DATA;
        end else begin
          arvalid_d  = 1'b1;
        end
      end
      ST_DATA: begin
        if (r_hs_s) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (out_rlast_i) begin
            state_d = ST_IDLE;
            grant_d = '0;
            if (beat_cnt_q == len_q) begin
              ptr_d = gidx_q;
            end else begin
              err_d = 1'b1;
            end
          end else if (beat_cnt_q == len_q) begin
            // Burst overran its length; keep draining until the slave ends it.
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        grant_d   = '0;
      end
    endcase
  end

  // State and output registers; reset puts port 0 first in round-robin order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      id_q       <= '0;
      len_q      <= 8'h00;
      burst_q    <= 2'b00;
      size_q     <= 3'b000;
      arvalid_q  <= 1'b0;
      grant_q    <= '0;
      gidx_q     <= '0;
      beat_cnt_q <= 8'h00;
      err_q      <= 1'b0;
      ptr_q      <= PW'(NUM_PORTS - 1);
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
      arvalid_q  <= arvalid_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
    end
  end

  assign in_arready_o  = (state_q == ST_IDLE && win_valid_s) ? win_onehot_s : '0;
  assign out_arvalid_o = arvalid_q;
  assign out_araddr_o  = (SEG_STRIP != 0) ? {3'b000, addr_q[28:0]} : addr_q;
  assign out_arid_o    = id_q;
  assign out_arlen_o   = len_q;
  assign out_arburst_o = burst_q;
  assign out_arsize_o  = size_q;
  assign grant_o       = grant_q;
  assign err_o         = err_q;

  // R path: only the owner sees RVALID, and only the owner's RREADY reaches downstream.
  assign in_rvalid_o   = (state_q == ST_DATA) ? (grant_q & {NUM_PORTS{out_rvalid_i}}) : '0;
  assign out_rready_o  = (state_q == ST_DATA) && ((grant_q & in_rready_i) != '0);
  assign in_rdata_o    = out_rdata_i;
  assign in_rresp_o    = out_rresp_i;
  assign in_rid_o      = out_rid_i;
  assign in_rlast_o    = out_rlast_i;

endmodule

// File: tb/tb_psf_axi_rd_arb.sv
// Directed bench for psf_axi_rd_arb: a round-robin/segment-stripping instance
// and a fixed-priority/no-strip instance driven by the same stimulus.
module tb_psf_axi_rd_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  arvalid;
  logic [63:0] araddr;
  logic [7:0]  arid;
  logic [15:0] arlen;
  logic [3:0]  arburst;
  logic [5:0]  arsize;
  logic [1:0]  rready;
  logic        out_arready, out_rvalid, out_rlast;
  logic [31:0] out_rdata;
  logic [1:0]  out_rresp;
  logic [3:0]  out_rid;

  logic [1:0]  arready, rvalid, grant;
  logic [31:0] rdata, oaraddr;
  logic [1:0]  rresp, oarburst;
  logic [3:0]  rid, oarid;
  logic        rlast, oarvalid, orready, err;
  logic [7:0]  oarlen;
  logic [2:0]  oarsize;

  logic [1:0]  fp_arready, fp_rvalid, fp_grant;
  logic [31:0] fp_rdata, fp_oaraddr;
  logic [1:0]  fp_rresp, fp_oarburst;
  logic [3:0]  fp_rid, fp_oarid;
  logic        fp_rlast, fp_oarvalid, fp_orready, fp_err;
  logic [7:0]  fp_oarlen;
  logic [2:0]  fp_oarsize;

  int n_chk  = 0;
  int n_fail = 0;

  psf_axi_rd_arb #(.NUM_PORTS(2), .ARB_RR(1), .SEG_STRIP(1), .ID_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_arvalid_i(arvalid), .in_araddr_i(araddr), .in_arid_i(arid),
    .in_arlen_i(arlen), .in_arburst_i(arburst), .in_arsize_i(arsize),
    .in_arready_o(arready), .in_rvalid_o(rvalid), .in_rdata_o(rdata),
    .in_rresp_o(rresp), .in_rid_o(rid), .in_rlast_o(rlast), .in_rready_i(rready),
    .out_arvalid_o(oarvalid), .out_araddr_o(oaraddr), .out_arid_o(oarid),
    .out_arlen_o(oarlen), .out_arburst_o(oarburst), .out_arsize_o(oarsize),
    .out_arready_i(out_arready), .out_rvalid_i(out_rvalid), .out_rdata_i(out_rdata),
    .out_rresp_i(out_rresp), .out_rid_i(out_rid), .out_rlast_i(out_rlast),
    .out_rready_o(orready), .grant_o(grant), .err_o(err)
  );

  psf_axi_rd_arb #(.NUM_PORTS(2), .ARB_RR(0), .SEG_STRIP(0), .ID_W(4)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .in_arvalid_i(arvalid), .in_araddr_i(araddr), .in_arid_i(arid),
    .in_arlen_i(arlen), .in_arburst_i(arburst), .in_arsize_i(arsize),
    .in_arready_o(fp_arready), .in_rvalid_o(fp_rvalid), .in_rdata_o(fp_rdata),
    .in_rresp_o(fp_rresp), .in_rid_o(fp_rid), .in_rlast_o(fp_rlast), .in_rready_i(rready),
    .out_arvalid_o(fp_oarvalid), .out_araddr_o(fp_oaraddr), .out_arid_o(fp_oarid),
    .out_arlen_o(fp_oarlen), .out_arburst_o(fp_oarburst), .out_arsize_o(fp_oarsize),
    .out_arready_i(out_arready), .out_rvalid_i(out_rvalid), .out_rdata_i(out_rdata),
    .out_rresp_i(out_rresp), .out_rid_i(out_rid), .out_rlast_i(out_rlast),
    .out_rready_o(fp_orready), .grant_o(fp_grant), .err_o(fp_err)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [3:0] id, input logic [7:0] len);
    arvalid[p]         = v;
    araddr[p*32 +: 32] = a;
    arid[p*4 +: 4]     = id;
    arlen[p*8 +: 8]    = len;
    arburst[p*2 +: 2]  = 2'b01;
    arsize[p*3 +: 3]   = 3'b010;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    arvalid     = 2'b00;
    out_arready = 1'b0;
    out_rvalid  = 1'b0;
    out_rlast   = 1'b0;
    rready      = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Accept the AR on the downstream side after one ADDR cycle.
  task automatic addr_accept();
    out_arready = 1'b1;
    tick();
    out_arready = 1'b0;
  endtask

  logic [1:0] exp_g;

  // Directed scenario sequence.
  initial begin
    araddr = 64'h0; arid = 8'h0; arlen = 16'h0; arburst = 4'h0; arsize = 6'h0;
    out_rdata = 32'h0; out_rresp = 2'b00; out_rid = 4'h0;
    do_reset();

    // Reset state
    #1;
    chk("rst_arvalid", oarvalid, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_arready", arready, 2'b00);
    chk("rst_rready", orready, 1'b0);
    chk("rst_araddr", oaraddr, 32'h0);

    // Single master, len 3, segment stripping
    set_req(0, 1'b1, 32'hBFC0_0100, 4'h5, 8'd3);
    #1;
    chk("t1_arready", arready, 2'b01);
    tick();
    arvalid = 2'b00;
    #1;
    chk("t1_arvalid", oarvalid, 1'b1);
    chk("t1_araddr", oaraddr, 32'h1FC0_0100);
    chk("t1_fp_araddr", fp_oaraddr, 32'hBFC0_0100);
    chk("t1_arlen", oarlen, 8'd3);
    chk("t1_arid", oarid, 4'h5);
    chk("t1_arburst", oarburst, 2'b01);
    chk("t1_arsize", oarsize, 3'b010);
    chk("t1_grant", grant, 2'b01);
    addr_accept();
    #1;
    chk("t1_arvalid_low", oarvalid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      out_rvalid = 1'b1;
      out_rdata  = 32'h11 * (b + 1);
      out_rid    = 4'h5;
      out_rlast  = (b == 3);
      #1;
      chk("t1_rvalid", rvalid, 2'b01);
      chk("t1_rdata", rdata, 32'h11 * (b + 1));
      chk("t1_rready", orready, 1'b1);
      tick();
    end
    chk("t1_rid", rid, 4'h5);
    out_rvalid = 1'b0;
    out_rlast  = 1'b0;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_rready", orready, 1'b0);
    chk("t1_err", err, 1'b0);

    // Round-robin fairness vs. fixed priority, both ports requesting len 0
    do_reset();
    set_req(0, 1'b1, 32'h0000_1000, 4'h1, 8'd0);
    set_req(1, 1'b1, 32'h0000_2000, 4'h2, 8'd0);
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_arready", arready, exp_g);
      chk("fp_arready", fp_arready, 2'b01);
      tick();
      #1;
      chk("rr_grant", grant, exp_g);
      chk("fp_grant", fp_grant, 2'b01);
      chk("rr_arready_wait", arready, 2'b00);
      chk("rr_araddr", oaraddr, (t % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      addr_accept();
      out_rvalid = 1'b1;
      out_rlast  = 1'b1;
      #1;
      chk("rr_rvalid", rvalid, exp_g);
      chk("rr_arready_data", arready, 2'b00);
      tick();
      out_rvalid = 1'b0;
      out_rlast  = 1'b0;
      if (t == 3) begin
        arvalid = 2'b00;
      end
    end

    // Back-pressure on AR and R, port 1, len 2
    do_reset();
    set_req(1, 1'b1, 32'h8000_1000, 4'h3, 8'd2);
    #1;
    chk("bp_arready", arready, 2'b10);
    tick();
    arvalid = 2'b00;
    repeat (5) begin
      #1;
      chk("bp_arvalid", oarvalid, 1'b1);
      chk("bp_araddr", oaraddr, 32'h0000_1000);
      chk("bp_arlen", oarlen, 8'd2);
      chk("bp_arid", oarid, 4'h3);
      chk("bp_rready_addr", orready, 1'b0);
      tick();
    end
    addr_accept();
    out_rvalid = 1'b1; out_rdata = 32'hA0; out_rid = 4'h3; out_rlast = 1'b0;
    rready = 2'b10;
    #1;
    chk("bp_rvalid0", rvalid, 2'b10);
    chk("bp_rready0", orready, 1'b1);
    tick();
    out_rdata = 32'hA1;
    rready    = 2'b00;
    repeat (3) begin
      #1;
      chk("bp_stall_rready", orready, 1'b0);
      chk("bp_stall_rvalid", rvalid, 2'b10);
      chk("bp_stall_rdata", rdata, 32'hA1);
      tick();
    end
    rready = 2'b10;
    #1;
    chk("bp_rready1", orready, 1'b1);
    tick();
    out_rdata = 32'hA2; out_rlast = 1'b1;
    #1;
    chk("bp_rvalid2", rvalid, 2'b10);
    chk("bp_grant2", grant, 2'b10);
    tick();
    out_rvalid = 1'b0; out_rlast = 1'b0; rready = 2'b11;
    #1;
    chk("bp_idle_grant", grant, 2'b00);
    chk("bp_err", err, 1'b0);

    // Protocol error (a): len 3, rlast on beat 1
    do_reset();
    set_req(0, 1'b1, 32'h0000_0040, 4'h7, 8'd3);
    tick();
    arvalid = 2'b00;
    addr_accept();
    out_rvalid = 1'b1; out_rlast = 1'b0;
    tick();
    out_rlast = 1'b1;
    tick();
    out_rvalid = 1'b0; out_rlast = 1'b0;
    #1;
    chk("erra_err", err, 1'b1);
    chk("erra_grant", grant, 2'b00);
    chk("erra_rready", orready, 1'b0);

    // Protocol error (b): len 0, beat 0 without rlast
    do_reset();
    #1;
    chk("errb_rst_err", err, 1'b0);
    set_req(0, 1'b1, 32'h0000_0080, 4'h8, 8'd0);
    tick();
    arvalid = 2'b00;
    addr_accept();
    out_rvalid = 1'b1; out_rlast = 1'b0;
    tick();
    #1;
    chk("errb_err", err, 1'b1);
    chk("errb_grant_hold", grant, 2'b01);
    chk("errb_rready_hold", orready, 1'b1);
    tick();
    #1;
    chk("errb_grant_hold2", grant, 2'b01);
    out_rlast = 1'b1;
    tick();
    out_rvalid = 1'b0; out_rlast = 1'b0;
    #1;
    chk("errb_idle_grant", grant, 2'b00);
    chk("errb_err_sticky", err, 1'b1);

    // Asynchronous reset mid-burst
    do_reset();
    set_req(0, 1'b1, 32'h0000_00C0, 4'h9, 8'd0);
    tick();
    arvalid = 2'b00;
    addr_accept();
    out_rvalid = 1'b1; out_rlast = 1'b0;
    tick();
    #1;
    chk("ar_pre_err", err, 1'b1);
    chk("ar_pre_rready", orready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_arvalid", oarvalid, 1'b0);
    chk("ar_grant", grant, 2'b00);
    chk("ar_err", err, 1'b0);
    chk("ar_rready", orready, 1'b0);
    chk("ar_rvalid", rvalid, 2'b00);
    out_rvalid = 1'b0;
    set_req(0, 1'b1, 32'h0000_0100, 4'h1, 8'd0);
    set_req(1, 1'b1, 32'h0000_0200, 4'h2, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_post_arready", arready, 2'b01);
    tick();
    #1;
    chk("ar_post_grant", grant, 2'b01);
    arvalid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
